// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency single-port memory between fetch (IF) and load/store (LS)
// Ports: clk/reset (async, active-high); if_* fetch requester; ls_* load/store requester;
// mem_* memory macro strobes and data; busy = access outstanding.
// Build option ARB_ROUND_ROBIN_EN: alternate winners on contention instead of LS priority + starvation counter.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t     state_q, state_d;
  logic [3:0] lat_q, lat_d;
  logic       owner_q, owner_d;
  logic       ls_win;
`ifdef ARB_ROUND_ROBIN_EN
  // owner_q=1 means LS was granted last, so IF takes the next contended slot
  assign ls_win = ls_req && (!if_req || !owner_q);
`else
  logic [3:0] starve_q, starve_d;
  assign ls_win = ls_req && !(if_req && starve_q == 4'(STARVE_MAX));
  always_comb
    starve_d = state_q != S_IDLE ? starve_q :
               (if_gnt || !if_req) ? 4'd0 :
               (ls_gnt && starve_q != 4'(STARVE_MAX)) ? starve_q + 4'd1 : starve_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) starve_q <= '0;
    else starve_q <= starve_d;
`endif
  assign mem_addr  = ls_win ? ls_addr : if_addr;
  assign mem_wdata = ls_wdata;
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    owner_d   = owner_q;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    busy      = state_q == S_WAIT;
    if (state_q == S_IDLE) begin
      if_gnt = if_req && !ls_win;
      ls_gnt = ls_win;
      mem_en = if_gnt || ls_gnt;
      mem_we = ls_win && ls_we;
      if (mem_en) begin
        state_d = S_WAIT;
        lat_d   = 4'(MEM_LAT - 1);
        owner_d = ls_win;
      end
    end else if (lat_q != 4'd0) begin
      lat_d = lat_q - 4'd1;
    end else begin
      state_d   = S_IDLE;
      if_rvalid = !owner_q;
      ls_rvalid = owner_q;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      owner_q <= owner_d;
    end
endmodule
